// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for a simple in-order core.
// It walks each instruction through FETCH, DECODE, EXEC, optional MEM and WB,
// and owns the architectural PC, the latched instruction and the cycle and
// retire counters. The core stops in HALT on ebreak, on a misaligned next PC,
// or when a memory handshake waits too long. Only reset leaves HALT.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-low reset
//   imem_req     instruction fetch request (high for the whole FETCH state)
//   imem_addr    fetch address, always equal to pc
//   imem_ready   fetch data valid; sampled only in FETCH
//   imem_rdata   fetched instruction word
//   instr        latched current instruction
//   pc           architectural PC
//   pc_next      next PC from the datapath
//   is_mem       decode flag: load or store
//   dmem_req     data memory request (high for the whole MEM state)
//   dmem_ready   data access complete; sampled only in MEM
//   rf_we_dec    decode flag: instruction writes rd
//   rf_wen       register file write enable, one cycle in WB
//   ebreak       decode flag: instruction is ebreak
//   halted       core stopped
//   halt_cause   0 none, 1 ebreak, 2 misaligned pc_next, 3 memory timeout
//   state        FSM state encoding, for debug
//   cycle_cnt    cycles since reset, not counting HALT
//   instret_cnt  retired instructions
module cpu_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned TIMEOUT  = 255,
    localparam int unsigned XLEN    = 64,
    localparam int unsigned ILEN    = 32,
    localparam int unsigned STATE_W = 3,
    localparam int unsigned CAUSE_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [ILEN-1:0]    imem_rdata,
    output logic [ILEN-1:0]    instr,
    output logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    pc_next,
    input  logic               is_mem,
    output logic               dmem_req,
    input  logic               dmem_ready,
    input  logic               rf_we_dec,
    output logic               rf_wen,
    input  logic               ebreak,
    output logic               halted,
    output logic [CAUSE_W-1:0] halt_cause,
    output logic [STATE_W-1:0] state,
    output logic [XLEN-1:0]    cycle_cnt,
    output logic [XLEN-1:0]    instret_cnt
);

    localparam int unsigned WAIT_W = 32;
    // One extra bit so the timeout compare cannot wrap.
    localparam int unsigned CMP_W  = WAIT_W + 1;

    localparam logic [ILEN-1:0]    NOP_INSTR      = ILEN'(32'h0000_0013);
    localparam logic [CAUSE_W-1:0] CAUSE_NONE     = CAUSE_W'(0);
    localparam logic [CAUSE_W-1:0] CAUSE_EBREAK   = CAUSE_W'(1);
    localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = CAUSE_W'(2);
    localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT  = CAUSE_W'(3);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_q;
    logic [WAIT_W-1:0]   wait_d;
    logic [ILEN-1:0]     instr_d;
    logic [XLEN-1:0]     pc_d;
    logic [XLEN-1:0]     cycle_d;
    logic [XLEN-1:0]     instret_d;
    logic [CAUSE_W-1:0]  cause_d;
    logic                imem_req_d;
    logic                dmem_req_d;
    logic                rf_wen_d;
    logic                halted_d;
    logic                wait_hit;
    logic                pc_aligned;
    logic                counting;

    assign imem_addr = pc;
    assign state     = state_q;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            instr       <= NOP_INSTR;
            pc          <= RESET_PC;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            halt_cause  <= CAUSE_NONE;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            rf_wen      <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            instr       <= instr_d;
            pc          <= pc_d;
            cycle_cnt   <= cycle_d;
            instret_cnt <= instret_d;
            halt_cause  <= cause_d;
            imem_req    <= imem_req_d;
            dmem_req    <= dmem_req_d;
            rf_wen      <= rf_wen_d;
            halted      <= halted_d;
        end
    end

    // Next-state, datapath register updates and next output values.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        instr_d    = instr;
        pc_d       = pc;
        cycle_d    = cycle_cnt;
        instret_d  = instret_cnt;
        cause_d    = halt_cause;
        counting   = 1'b0;

        // This waiting cycle is the TIMEOUT-th one without ready.
        wait_hit   = (CMP_W'(wait_q) + CMP_W'(1)) >= CMP_W'(TIMEOUT);
        pc_aligned = (pc_next[1:0] == 2'b00);

        case (state_q)
            S_IDLE: begin
                counting = 1'b1;
                wait_d   = '0;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                counting = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end else if (wait_hit) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                counting = 1'b1;
                if (ebreak) begin
                    cause_d = CAUSE_EBREAK;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                counting = 1'b1;
                if (is_mem) begin
                    wait_d  = '0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                counting = 1'b1;
                if (dmem_ready) begin
                    state_d = S_WB;
                end else if (wait_hit) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                counting = 1'b1;
                // A misaligned target stops the core before retirement.
                if (pc_aligned) begin
                    pc_d      = pc_next;
                    instret_d = instret_cnt + XLEN'(1);
                    wait_d    = '0;
                    state_d   = S_FETCH;
                end else begin
                    cause_d = CAUSE_MISALIGN;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // Unreachable encoding: park in HALT.
                cause_d = CAUSE_TIMEOUT;
                state_d = S_HALT;
            end
        endcase

        if (counting) begin
            cycle_d = cycle_cnt + XLEN'(1);
        end

        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        halted_d   = (state_d == S_HALT);
        // Write-back enable is suppressed for x0 and for a misaligned target.
        rf_wen_d   = (state_d == S_WB) && rf_we_dec &&
                     (instr_d[11:7] != 5'd0) && pc_aligned;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: an instruction-level model predicts
// the per-cycle outputs (queue of expected records) that one compare process
// checks on every falling edge, plus literal checks at key points.
module tb_cpu_sequencer;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam int          TMO    = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] pc_next;
    logic        is_mem;
    logic        dmem_req;
    logic        dmem_ready;
    logic        rf_we_dec;
    logic        rf_wen;
    logic        ebreak;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [2:0]  state;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    cpu_sequencer #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr(instr), .pc(pc), .pc_next(pc_next),
        .is_mem(is_mem), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .rf_we_dec(rf_we_dec), .rf_wen(rf_wen), .ebreak(ebreak),
        .halted(halted), .halt_cause(halt_cause), .state(state),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        ireq;
        logic [63:0] addr;
        logic [31:0] ins;
        logic [63:0] pc;
        logic        dreq;
        logic        wen;
        logic        hlt;
        logic [1:0]  cause;
        logic [63:0] cyc;
        logic [63:0] ret;
    } obs_t;

    obs_t        expq[$];
    obs_t        cmp_e;
    obs_t        cmp_a;
    int          total = 0;
    int          bad   = 0;
    bit          model_on = 1'b0;
    bit          stop;

    // Architectural model state.
    logic [63:0] m_pc;
    logic [63:0] m_cyc;
    logic [63:0] m_ret;
    logic [31:0] m_instr;
    logic [1:0]  m_cause;
    bit          m_was_halt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void push(input logic [2:0] st, input logic wen);
        obs_t e;
        e.st    = st;
        e.ireq  = (st == 3'd1);
        e.addr  = m_pc;
        e.ins   = m_instr;
        e.pc    = m_pc;
        e.dreq  = (st == 3'd4);
        e.wen   = wen;
        e.hlt   = (st == 3'd6);
        e.cause = m_cause;
        e.cyc   = m_cyc;
        e.ret   = m_ret;
        expq.push_back(e);
    endfunction

    task automatic noise_flags();
        ebreak    = 1'($urandom);
        is_mem    = 1'($urandom);
        rf_we_dec = 1'($urandom);
        pc_next   = {$urandom, $urandom};
    endtask

    // Advance one clock; the model's state for the new cycle is st.
    task automatic tick(input logic [2:0] st, input logic wen);
        @(posedge clk);
        #1;
        if (!m_was_halt) m_cyc = m_cyc + 64'd1;
        m_was_halt = (st == 3'd6);
        push(st, wen);
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        imem_rdata = $urandom;
    endtask

    task automatic halt_seq(input logic [1:0] cause);
        m_cause = cause;
        tick(3'd6, 1'b0);
        noise_flags();
    endtask

    task automatic halt_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick(3'd6, 1'b0);
            noise_flags();
        end
    endtask

    task automatic do_reset();
        model_on = 1'b0;
        expq.delete();
        rst = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        imem_rdata = 32'h0;
        noise_flags();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_pc", pc, 64'h0000_0000_8000_0000);
        chk("rst_instr", 64'(instr), 64'h13);
        chk("rst_counters", cycle_cnt | instret_cnt, 64'd0);
        chk("rst_flags", 64'({imem_req, dmem_req, rf_wen, halted, halt_cause}), 64'd0);
        rst = 1'b1;
        m_pc = RST_PC;
        m_instr = 32'h0000_0013;
        m_cyc = 64'd0;
        m_ret = 64'd0;
        m_cause = 2'd0;
        m_was_halt = 1'b0;
        push(3'd0, 1'b0);
        model_on = 1'b1;
    endtask

    // One instruction from the cycle before FETCH through WB (or into HALT).
    task automatic do_instr(input int idly, input logic [31:0] word, input bit ebk,
                            input bit mem, input int ddly, input bit we,
                            input logic [63:0] tgt, input int abort_at,
                            output bit stp);
        logic wen;
        stp = 1'b0;
        for (int i = 0; ; i++) begin
            tick(3'd1, 1'b0);
            noise_flags();
            imem_ready = (i == idly);
            if (i == idly) begin
                imem_rdata = word;
                break;
            end
            if (i == TMO - 1) begin
                halt_seq(2'd3);
                stp = 1'b1;
                return;
            end
        end
        m_instr = word;
        tick(3'd2, 1'b0);
        ebreak = ebk;
        is_mem = mem;
        rf_we_dec = we;
        pc_next = tgt;
        if (ebk) begin
            halt_seq(2'd1);
            stp = 1'b1;
            return;
        end
        tick(3'd3, 1'b0);
        if (mem) begin
            for (int i = 0; ; i++) begin
                tick(3'd4, 1'b0);
                dmem_ready = (i == ddly);
                if (i == ddly) break;
                if (i == abort_at) begin
                    stp = 1'b1;
                    return;
                end
                if (i == TMO - 1) begin
                    halt_seq(2'd3);
                    stp = 1'b1;
                    return;
                end
            end
        end
        wen = we && (word[11:7] != 5'd0) && (tgt[1:0] == 2'b00);
        tick(3'd5, wen);
        if (tgt[1:0] != 2'b00) begin
            halt_seq(2'd2);
            stp = 1'b1;
            return;
        end
        m_pc = tgt;
        m_ret = m_ret + 64'd1;
    endtask

    function automatic int pick_dly();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 60) return 0;
        if (r < 97) return int'($urandom_range(1, 4));
        if (r < 99) return TMO - 1;
        return TMO;
    endfunction

    initial begin
        rst = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        imem_rdata = 32'h0;
        noise_flags();

        fork
            forever begin
                @(negedge clk);
                if (model_on) begin
                    cmp_a.st = state;       cmp_a.ireq = imem_req;   cmp_a.addr = imem_addr;
                    cmp_a.ins = instr;      cmp_a.pc = pc;           cmp_a.dreq = dmem_req;
                    cmp_a.wen = rf_wen;     cmp_a.hlt = halted;      cmp_a.cause = halt_cause;
                    cmp_a.cyc = cycle_cnt;  cmp_a.ret = instret_cnt;
                    total++;
                    if (expq.size() == 0) begin
                        bad++;
                        $display("FAIL cycle_model: no expectation at %0t, got st=%0d", $time, state);
                    end else begin
                        cmp_e = expq.pop_front();
                        if (cmp_a !== cmp_e) begin
                            bad++;
                            $display("FAIL cycle@%0t: got st=%0d ireq=%b addr=%h ins=%h pc=%h dreq=%b wen=%b hlt=%b cause=%0d cyc=%0d ret=%0d want st=%0d ireq=%b addr=%h ins=%h pc=%h dreq=%b wen=%b hlt=%b cause=%0d cyc=%0d ret=%0d",
                                     $time, cmp_a.st, cmp_a.ireq, cmp_a.addr, cmp_a.ins, cmp_a.pc, cmp_a.dreq,
                                     cmp_a.wen, cmp_a.hlt, cmp_a.cause, cmp_a.cyc, cmp_a.ret,
                                     cmp_e.st, cmp_e.ireq, cmp_e.addr, cmp_e.ins, cmp_e.pc, cmp_e.dreq,
                                     cmp_e.wen, cmp_e.hlt, cmp_e.cause, cmp_e.cyc, cmp_e.ret);
                        end
                    end
                end
            end
        join_none

        // addi x1 with single-cycle ready, then ebreak.
        do_reset();
        do_instr(0, 32'h0010_0093, 1'b0, 1'b0, 0, 1'b1, m_pc + 64'd4, -1, stop);
        chk("addi_wb_state", 64'(state), 64'd5);
        chk("addi_wb_rf_wen", 64'(rf_wen), 64'd1);
        chk("addi_wb_cycle", cycle_cnt, 64'd4);
        do_instr(0, 32'h0010_0073, 1'b1, 1'b0, 0, 1'b0, m_pc + 64'd4, -1, stop);
        chk("ebreak_pc", pc, 64'h0000_0000_8000_0004);
        chk("ebreak_instret", instret_cnt, 64'd1);
        chk("ebreak_cause", 64'(halt_cause), 64'd1);
        chk("ebreak_cycle", cycle_cnt, 64'd7);
        halt_ticks(5);
        chk("ebreak_cycle_frozen", cycle_cnt, 64'd7);

        // Delayed fetch, load with delayed dmem, x0 write, misaligned target.
        do_reset();
        do_instr(3, 32'h0050_0293, 1'b0, 1'b0, 0, 1'b1, m_pc + 64'd4, -1, stop);
        chk("slow_fetch_instr", 64'(instr), 64'h0050_0293);
        chk("slow_fetch_cycle", cycle_cnt, 64'd7);
        do_instr(0, 32'h0002_a303, 1'b0, 1'b1, 2, 1'b1, m_pc + 64'd4, -1, stop);
        chk("load_wb_cycle", cycle_cnt, 64'd14);
        chk("load_wb_rf_wen", 64'(rf_wen), 64'd1);
        do_instr(0, 32'h0000_0013, 1'b0, 1'b0, 0, 1'b1, m_pc + 64'd4, -1, stop);
        chk("x0_rf_wen", 64'(rf_wen), 64'd0);
        do_instr(0, 32'h0010_0093, 1'b0, 1'b0, 0, 1'b1, 64'h0000_0000_8000_0002, -1, stop);
        chk("misalign_cause", 64'(halt_cause), 64'd2);
        chk("misalign_pc", pc, 64'h0000_0000_8000_000C);
        chk("misalign_instret", instret_cnt, 64'd3);
        chk("misalign_rf_wen", 64'(rf_wen), 64'd0);
        halt_ticks(3);

        // Fetch timeout boundary: TIMEOUT-1 waits survive, TIMEOUT waits halt.
        do_reset();
        do_instr(TMO - 1, 32'h0010_0093, 1'b0, 1'b0, 0, 1'b1, m_pc + 64'd4, -1, stop);
        chk("near_timeout_state", 64'(state), 64'd5);
        chk("near_timeout_cycle", cycle_cnt, 64'd258);
        do_instr(TMO, 32'h0010_0093, 1'b0, 1'b0, 0, 1'b1, m_pc + 64'd4, -1, stop);
        chk("fetch_timeout_cause", 64'(halt_cause), 64'd3);
        chk("fetch_timeout_cycle", cycle_cnt, 64'd514);
        halt_ticks(3);

        // Data memory timeout.
        do_reset();
        do_instr(0, 32'h0002_a303, 1'b0, 1'b1, TMO, 1'b1, m_pc + 64'd4, -1, stop);
        chk("dmem_timeout_cause", 64'(halt_cause), 64'd3);
        chk("dmem_timeout_instret", instret_cnt, 64'd0);

        // Reset in the middle of a MEM wait, then a fresh fetch.
        do_reset();
        do_instr(0, 32'h0002_a303, 1'b0, 1'b1, 5, 1'b1, m_pc + 64'd4, 1, stop);
        @(negedge clk);
        #1;
        model_on = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_state", 64'(state), 64'd0);
        chk("abort_pc", pc, 64'h0000_0000_8000_0000);
        chk("abort_instr", 64'(instr), 64'h13);
        chk("abort_outputs", 64'({imem_req, dmem_req, rf_wen, halted}), 64'd0);
        chk("abort_counters", cycle_cnt | instret_cnt, 64'd0);
        do_reset();
        do_instr(0, 32'h0010_0093, 1'b0, 1'b0, 0, 1'b1, m_pc + 64'd4, -1, stop);
        chk("refetch_pc", pc, 64'h0000_0000_8000_0000);

        // Randomized programs.
        for (int p = 0; p < 30; p++) begin
            do_reset();
            stop = 1'b0;
            for (int n = 0; n < 25; n++) begin
                int          idly;
                int          ddly;
                bit          ebk;
                bit          mem;
                bit          we;
                logic [63:0] tgt;
                idly = pick_dly();
                ddly = pick_dly();
                ebk  = ($urandom_range(0, 29) == 0);
                mem  = ($urandom_range(0, 2) == 0);
                we   = 1'($urandom);
                if ($urandom_range(0, 29) == 0)
                    tgt = {$urandom, $urandom} | 64'($urandom_range(1, 3));
                else if ($urandom_range(0, 3) == 0)
                    tgt = {$urandom, $urandom} & ~64'h3;
                else
                    tgt = m_pc + 64'd4;
                do_instr(idly, $urandom, ebk, mem, ddly, we, tgt, -1, stop);
                if (stop) break;
            end
            if (stop) halt_ticks(3);
        end

        @(negedge clk);
        #1;
        model_on = 1'b0;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL model_drain: got %0d pending want 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
